// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and size helpers for the RAM request controller and its lane formatter.
package mem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_DATA = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic [3:0] SIZE_BYTES [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

  // Offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(size_e s);
    return 3'(SIZE_BYTES[s] - 4'd1);
  endfunction

  function automatic logic misaligned(size_e s, logic [2:0] off);
    return |(off & align_mask(s));
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter: load extract with sign/zero extension and store merge.
module mem_lane_fmt
  import mem_req_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        is_signed,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [63:0] merged
);

  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] size_mask;

  assign sh   = {offset, 3'b000};
  assign lane = word >> sh;

  always_comb begin
    size_mask = '1;
    rdata     = lane;
    case (size_e'(size))
      SZ_B: begin
        size_mask = 64'h0000_0000_0000_00FF;
        rdata     = {{56{is_signed & lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        rdata     = {{48{is_signed & lane[15]}}, lane[15:0]};
      end
      SZ_W: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        rdata     = {{32{is_signed & lane[31]}}, lane[31:0]};
      end
      default: begin
        size_mask = '1;
        rdata     = lane;
      end
    endcase
  end

  assign merged = (word & ~(size_mask << sh)) | ((wdata & size_mask) << sh);

endmodule

// File: rtl/mem_req_ctrl.sv
// Byte-addressed load/store controller in front of a 64-bit single-port synchronous RAM.
// MEM_REQ_CTRL_ALIGN_CHECK_EN: flag misaligned requests with resp_err; otherwise round the offset down.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+2:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  state_e                  state;
  logic                    wr_q;
  size_e                   size_q;
  logic                    sgn_q;
  logic [2:0]              off_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wbuf;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    mis;
  logic [2:0]              off_in;
  logic [DATA_WIDTH-1:0]   ext_rdata;
  logic [DATA_WIDTH-1:0]   merged;

`ifdef MEM_REQ_CTRL_ALIGN_CHECK_EN
  assign mis    = misaligned(size_e'(req_size), req_addr[2:0]);
  assign off_in = req_addr[2:0];
`else
  assign mis    = 1'b0;
  assign off_in = req_addr[2:0] & ~align_mask(size_e'(req_size));
`endif

  // wbuf holds the raw store data until DATA, so it doubles as the merge source.
  mem_lane_fmt u_lane_fmt (
    .size      (size_q),
    .offset    (off_q),
    .is_signed (sgn_q),
    .word      (ram_data_out),
    .wdata     (wbuf),
    .rdata     (ext_rdata),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_B;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      wbuf    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            size_q  <= size_e'(req_size);
            sgn_q   <= req_signed;
            off_q   <= off_in;
            addr_q  <= req_addr[ADDR_WIDTH+2:3];
            wbuf    <= req_wdata;
            rdata_q <= '0;
            err_q   <= mis;
            if (mis)
              state <= ST_RESP;
            else if (req_write && size_e'(req_size) == SZ_D)
              state <= ST_WR;
            else
              state <= ST_RD;
          end
        end
        ST_RD:   state <= ST_DATA;
        ST_DATA: begin
          if (wr_q) begin
            wbuf  <= merged;
            state <= ST_WR;
          end else begin
            rdata_q <= ext_rdata;
            state   <= ST_RESP;
          end
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == ST_IDLE);
  assign resp_valid  = (state == ST_RESP);
  assign ram_oe      = (state == ST_RD);
  assign ram_we      = (state == ST_WR);
  assign ram_address = addr_q;
  assign ram_data_in = wbuf;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl with a behavioural RAM and a byte-level reference model.
module tb_mem_req_ctrl;

`ifdef MEM_REQ_CTRL_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [12:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  ram_address;
  logic        ram_we;
  logic        ram_oe;
  logic [63:0] ram_data_in;
  logic [63:0] ram_data_out = '0;

  logic [63:0] mem     [0:1023] = '{default: '0};
  logic [63:0] ref_mem [0:1023] = '{default: '0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_address  (ram_address),
    .ram_we       (ram_we),
    .ram_oe       (ram_oe),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data_in;
    if (ram_oe) ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state for the single outstanding request
  bit          exp_valid = 0;
  bit          first = 0;
  int          k = 0, we_cnt = 0, oe_cnt = 0;
  int          exp_lat = 0, exp_we = 0, exp_oe = 0;
  logic [63:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  logic [9:0]  exp_wa = '0;
  bit          pst_en = 0;
  logic [63:0] pst_val = '0;

  task automatic model_accept();
    logic [63:0] cur, val;
    int unsigned nb, off;
    bit          mis;
    cur = ref_mem[req_addr[12:3]];
    nb  = 1 << req_size;
    off = req_addr[2:0];
    mis = CHK && ((off % nb) != 0);
    off = off - (off % nb);
    exp_wa = req_addr[12:3];
    exp_rdata = '0;
    exp_err = mis;
    pst_en = 0;
    pst_val = cur;
    if (mis) begin
      exp_lat = 1; exp_we = 0; exp_oe = 0;
    end else if (!req_write) begin
      val = '0;
      for (int unsigned i = 0; i < nb; i++) val[8*i +: 8] = cur[8*(off+i) +: 8];
      if (req_signed && nb < 8 && val[8*nb-1]) val = val | ~((64'd1 << (8*nb)) - 64'd1);
      exp_rdata = val;
      exp_lat = 3; exp_we = 0; exp_oe = 1;
    end else begin
      for (int unsigned i = 0; i < nb; i++) pst_val[8*(off+i) +: 8] = req_wdata[8*i +: 8];
      pst_en = 1;
      exp_lat = (nb == 8) ? 2 : 4;
      exp_we = 1;
      exp_oe = (nb == 8) ? 0 : 1;
    end
    exp_valid = 1; first = 1; k = 0; we_cnt = 0; oe_cnt = 0;
  endtask

  // Compare process: every negedge, DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_valid = 0;
        pst_en = 0;
      end else begin
        chk("we_oe_excl", 64'(ram_we & ram_oe), 64'd0);
        chk("ready_valid_excl", 64'(req_ready & resp_valid), 64'd0);
        if (exp_valid) begin
          k++;
          if (ram_we) begin
            we_cnt++;
            chk("ram_data_in", ram_data_in, pst_val);
          end
          if (ram_oe) oe_cnt++;
          chk("ram_address", 64'(ram_address), 64'(exp_wa));
          if (resp_valid) begin
            if (first) begin
              chk("latency", 64'(k), 64'(exp_lat));
              chk("we_cycles", 64'(we_cnt), 64'(exp_we));
              chk("oe_cycles", 64'(oe_cnt), 64'(exp_oe));
              first = 0;
            end
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_err", 64'(resp_err), 64'(exp_err));
            if (resp_ready) begin
              if (pst_en) ref_mem[exp_wa] = pst_val;
              pst_en = 0;
              exp_valid = 0;
            end
          end
        end else begin
          chk("spurious_resp", 64'(resp_valid), 64'd0);
        end
        if (req_valid && req_ready) model_accept();
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [12:0] a, input logic [63:0] wd);
    bit ok = 0;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [63:0] rd, output logic er);
    bit ok = 0;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin ok = 1; rd = resp_rdata; er = resp_err; break; end
    end
    chk("resp_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic xact(input string name, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [12:0] a, input logic [63:0] wd,
                      input logic [63:0] e_rd, input logic e_err, input int e_lat);
    int lat; logic [63:0] rd; logic er;
    send(w, sz, sg, a, wd);
    wait_resp(lat, rd, er);
    chk({name, "_lat"}, 64'(lat), 64'(e_lat));
    chk({name, "_rdata"}, rd, e_rd);
    chk({name, "_err"}, 64'(er), 64'(e_err));
  endtask

  initial begin
    int lat; logic [63:0] rd; logic er; bit ok;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_oe", 64'(ram_oe), 64'd0);
    chk("rst_ram_address", 64'(ram_address), 64'd0);
    chk("rst_ram_data_in", ram_data_in, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    xact("st_d1", 1, 2'd3, 0, 13'h28, 64'h0011223344556677, 64'd0, 0, 2);
    chk("mem5_a", mem[5], 64'h0011223344556677);
    xact("ld_b_s", 0, 2'd0, 1, 13'h29, 64'd0, 64'h0000000000000066, 0, 3);
    xact("ld_d", 0, 2'd3, 0, 13'h28, 64'd0, 64'h0011223344556677, 0, 3);
    xact("st_d2", 1, 2'd3, 0, 13'h28, 64'h00000000F0000000, 64'd0, 0, 2);
    xact("ld_w_s", 0, 2'd2, 1, 13'h28, 64'd0, 64'hFFFFFFFFF0000000, 0, 3);
    xact("ld_w_u", 0, 2'd2, 0, 13'h28, 64'd0, 64'h00000000F0000000, 0, 3);
    xact("ld_b_neg", 0, 2'd0, 1, 13'h2B, 64'd0, 64'hFFFFFFFFFFFFFFF0, 0, 3);
    xact("ld_h_u", 0, 2'd1, 0, 13'h2A, 64'd0, 64'h000000000000F000, 0, 3);
    xact("st_d3", 1, 2'd3, 0, 13'h28, 64'h0011223344556677, 64'd0, 0, 2);
    xact("st_h", 1, 2'd1, 0, 13'h2C, 64'h123456789ABCBEEF, 64'd0, 0, 4);
    chk("mem5_half", mem[5], 64'h0011BEEF44556677);
    xact("st_b", 1, 2'd0, 0, 13'h2F, 64'h5A5A5A5A5A5A5AA5, 64'd0, 0, 4);
    xact("st_w", 1, 2'd2, 0, 13'h28, 64'hFFFFFFFFDEADBEEF, 64'd0, 0, 4);
    xact("ld_d2", 0, 2'd3, 0, 13'h28, 64'd0, 64'hA511BEEFDEADBEEF, 0, 3);

    // Misaligned: error with the check, rounded-down access without it
    xact("mis_ld_w", 0, 2'd2, 0, 13'h2A, 64'd0,
         CHK ? 64'd0 : 64'h00000000DEADBEEF, CHK, CHK ? 1 : 3);
    xact("mis_st_h", 1, 2'd1, 0, 13'h2B, 64'h1111, 64'd0, CHK, CHK ? 1 : 4);
    chk("mem5_mis", mem[5], CHK ? 64'hA511BEEFDEADBEEF : 64'hA511BEEF1111BEEF);

    // Response back-pressure with a competing request pending
    resp_ready = 1'b0;
    send(0, 2'd1, 1, 13'h2E, 64'd0);
    wait_resp(lat, rd, er);
    chk("hold_lat", 64'(lat), 64'd3);
    chk("hold_first_rdata", rd, 64'hFFFFFFFFFFFFA511);
    req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 13'h2F; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_resp_valid", 64'(resp_valid), 64'd1);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_rdata", resp_rdata, 64'hFFFFFFFFFFFFA511);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat, rd, er);
    chk("b2b_lat", 64'(lat), 64'd3);
    chk("b2b_rdata", rd, 64'h00000000000000A5);

    // Reset asserted during the write cycle of a partial store
    send(1, 2'd0, 0, 13'h28, 64'd0);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_we) begin ok = 1; break; end
    end
    chk("wr_seen", 64'(ok), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_we", 64'(ram_we), 64'd0);
    chk("rst_wr_ready", 64'(req_ready), 64'd1);
    chk("rst_wr_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mem5_after_rst", mem[5], CHK ? 64'hA511BEEFDEADBEEF : 64'hA511BEEF1111BEEF);
    xact("ld_after_rst", 0, 2'd0, 0, 13'h28, 64'd0, 64'h00000000000000EF, 0, 3);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request controller that sits directly upstream of the single-port synchronous RAM (64-bit words, 1024 deep) and is the only block driving its address, write-enable, output-enable and write-data pins. It accepts byte-addressed load/store requests from the processor over a valid/ready handshake. It resolves byte, half, word and dword accesses against 64-bit RAM words, using read-modify-write for partial stores and sign/zero extension for loads. It returns one response per request.

## Interface
- DATA_WIDTH, 64, RAM word width; fixed at 64 because lane logic assumes 8 byte lanes.
- ADDR_WIDTH, 10, RAM word-address width; the request byte address is ADDR_WIDTH+3 bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0; ignored for stores.
- req_addr  in  ADDR_WIDTH+3  byte address, little-endian; [2:0] is the byte offset.
- req_wdata  in  64  store data, right-justified (low bits used).
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  64  load result (0 for stores and errors).
- resp_err  out  1  misaligned access; RAM untouched.
- ram_address  out  ADDR_WIDTH  = latched req_addr[ADDR_WIDTH+2:3].
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_data_in  out  64  RAM write data.
- ram_data_out  in  64  RAM read data; valid the cycle after a read edge, held until the next read.

## Operation
- States: IDLE, RD, DATA, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch write/size/signed/addr/wdata.
  - Misaligned request: go to RESP with resp_err=1.
  - Dword store: go to WR, with wbuf=req_wdata.
  - Any other request: go to RD.
- RD: ram_oe=1, ram_we=0. The RAM captures the word at the following edge. Next state is DATA.
- DATA: ram_data_out is valid.
  - Load: register the extracted lane into resp_rdata; next state is RESP.
  - Store: register the merged word into wbuf; next state is WR.
- WR: ram_we=1, ram_oe=0, ram_data_in=wbuf. Next state is RESP.
- RESP: resp_valid=1. When resp_ready is high, go to IDLE.
- Alignment rules: half requires addr[0]=0, word requires addr[1:0]=0, dword requires addr[2:0]=0. Byte accesses are always aligned.
- Lane position: the lane starts at bit offset*8.
  - Load extract: take size bits at the lane and extend them to 64.
  - Store merge: replace only the addressed lane with req_wdata[size bits-1:0]; all other bytes are kept from ram_data_out.
- ram_we and ram_oe are decoded from state and are never both high. ram_address and ram_data_in are stable in every state outside IDLE.

## Timing
- Reset: state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; ram_we=0, ram_oe=0, ram_address=0, ram_data_in=0.
- The cycle in which a request is accepted is cycle 0. resp_valid first goes high at:
  - cycle 1 for an error;
  - cycle 2 for a dword store;
  - cycle 3 for a load;
  - cycle 4 for a partial store.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake. req_ready and resp_valid are never high together.
- resp_ready held low: the controller stays in RESP with outputs stable; the RAM is idle.
- Reset mid-operation: ram_we drops asynchronously and no write completes. RAM contents are not reset. The interrupted request is dropped without a response.

## Configuration
- MEM_REQ_CTRL_ALIGN_CHECK_EN defined: misalignment detection as above; resp_err is driven.
- Macro not defined: no check. Offset bits below natural alignment are forced to 0 (access rounds down), and resp_err is tied to 0.

## Structure
- Package mem_req_ctrl_pkg holds:
  - size enum SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum;
  - the per-size byte-count constant.
- Sub-module mem_lane_fmt: combinational load extract/extend and store merge, with inputs (size, offset, signed, word, wdata).

## Test plan
- After reset, RAM word 5 = 0x0011223344556677 (via a dword store to 0x28). Load byte signed at 0x29 -> resp_rdata=0x0000000000000066, latency 3.
- Word 5 = 0x00000000_F0000000. Load word signed at 0x28 -> resp_rdata=0xFFFFFFFFF0000000. Same load unsigned -> 0x00000000F0000000.
- Word 5 = 0x0011223344556677. Store half 0xBEEF at 0x2C -> word 5 becomes 0x0011BEEF44556677. ram_we is high exactly one cycle and resp_valid is at cycle 4.
- Load word at 0x2A with the macro defined -> resp_err=1 at cycle 1; ram_we and ram_oe never assert.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0; the next request is accepted only after the handshake.
- Assert rst during the WR cycle of a partial store -> ram_we drops immediately, state returns to IDLE, and the RAM word keeps its old value.
